pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central sequencer for the 5-stage 16-bit pipeline. It drives the write enables, flushes and bubbles of the PC, F/D, D/X, X/M and M/W pipeline registers. It detects load-use hazards, squashes wrong-path fetches on taken branches, freezes the whole pipe during instruction- or data-memory stalls, and drains the pipe on HLT before asserting halted. It sits beside the decode stage and feeds the wen/rst inputs of every *_Flops block.

Parameters:
REG_W, 4, register-specifier width
DRAIN_CYCLES, 3, unstalled cycles between HLT leaving decode and halted asserting (X, M, WB drain)
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset (sampled on posedge clk; 0 = reset)
id_rs1  in  REG_W  decode source register 1
id_rs2  in  REG_W  decode source register 2
id_use1  in  1  decode instruction reads rs1
id_use2  in  1  decode instruction reads rs2
id_branch_taken  in  1  branch/jump resolved taken in decode
id_halt  in  1  HLT in decode
dx_memread  in  1  D/X holds a load
dx_regwrite  in  1  D/X writes a register
dx_rd  in  REG_W  D/X destination register
imem_stall  in  1  instruction memory not ready
dmem_stall  in  1  data memory not ready
pc_wen  out  1  PC register write enable
fd_wen  out  1  F/D write enable
dx_wen  out  1  D/X write enable
xm_wen  out  1  X/M write enable
mw_wen  out  1  M/W write enable
fd_flush  out  1  F/D loads NOP next edge
dx_bubble  out  1  D/X loads all-zero controls next edge
halted  out  1  pipeline drained after HLT
stall_cnt  out  CNT_W  stall-cycle counter (optional feature)
flush_cnt  out  CNT_W  flush-event counter (optional feature)

Behaviour:
- Outputs are combinational from state and inputs. The state register and drain counter update on posedge clk.
- Reset (rst==0 at an edge): state<=RUN, drain_cnt<=DRAIN_CYCLES, counters<=0. While rst==0: all *_wen=0, fd_flush=0, dx_bubble=0, halted=0. Reset mid-drain or mid-stall aborts immediately.
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- mem_stall = imem_stall | dmem_stall.
- load_use = dx_memread & dx_regwrite & (dx_rd!=0) & ((id_use1 & id_rs1==dx_rd) | (id_use2 & id_rs2==dx_rd)).
- Priority (highest first): mem_stall > load_use > halt > branch.
- RUN:
  - mem_stall: all wen=0, no flush/bubble; the same cycle is frozen; next state MEM_WAIT.
  - Else load_use: pc_wen=fd_wen=0, dx/xm/mw_wen=1, dx_bubble=1. Lasts exactly 1 cycle. Branch taken in the same cycle is ignored; it re-evaluates next cycle.
  - Else id_halt: pc_wen=0, fd_flush=1, other wen=1; next state DRAIN.
  - Else id_branch_taken: all wen=1, fd_flush=1 (1-cycle penalty).
  - Else all wen=1.
- MEM_WAIT: all wen=0 while mem_stall. The first cycle with mem_stall==0 evaluates as RUN (no lost cycle); the next state follows the RUN rules.
- DRAIN: pc_wen=0, fd_flush=1, dx/xm/mw_wen=!mem_stall. drain_cnt decrements only when !mem_stall. When drain_cnt==1 and decrementing, next state is HALTED.
- HALTED: all wen=0, halted=1. Only reset exits. id_branch_taken and id_halt are ignored.
- DRAIN_CYCLES==0 is illegal (assertion).

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: stall_cnt increments every cycle in which pc_wen==0 and state!=HALTED. flush_cnt increments on every cycle with fd_flush==1 in RUN. Both counters saturate at all-ones and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Package pipe_ctrl_pkg holds the state enum (RUN, MEM_WAIT, DRAIN, HALTED), the REG_W default and the NOP instruction constant 16'h0000.
- One sub-module, haz_sat_counter (CNT_W parameter, inc input, saturating), is instantiated twice under HAZ_PERF_CNT_EN.

Test Plan:
- Load-use: dx_memread=1, dx_regwrite=1, dx_rd=4'h3, id_use1=1, id_rs1=4'h3 -> one cycle of pc_wen=0, fd_wen=0, dx_bubble=1, then all wen=1. Same case with dx_rd=0 -> no stall.
- Branch: id_branch_taken=1 alone -> fd_flush=1 for 1 cycle, all wen=1. Branch with load_use active -> flush deferred one cycle.
- Mem stall: dmem_stall high for 4 cycles during a load_use -> all wen=0 for 4 cycles, then the load_use bubble cycle, then normal; flush_cnt unchanged, stall_cnt=5.
- Halt drain: id_halt=1, DRAIN_CYCLES=3, imem_stall pulse for 2 cycles mid-drain -> halted asserts exactly 5 cycles after halt accepted; afterwards all wen=0.
- Reset: rst=0 while in DRAIN or MEM_WAIT -> next cycle state RUN, halted=0, counters 0; all wen=1 once rst=1 with no hazard inputs.
- Saturation (HAZ_PERF_CNT_EN, CNT_W=4): hold imem_stall for 20 cycles -> stall_cnt stops at 4'hF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } ctrl_state_e;

  // Default register-specifier width (16 architectural registers).
  localparam int REG_W_DEF = 4;

  // Instruction word that F/D holds after a flush.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/haz_sat_counter.sv
// Saturating up-counter used for the optional hazard performance counters.
// Synchronous active-low reset; holds at all-ones once reached.
module haz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count qualifying cycles, stopping at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage 16-bit pipeline: load-use bubbles,
// taken-branch squashes, memory-stall freezes and HLT drain.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  input  logic             dx_memread,
  input  logic             dx_regwrite,
  input  logic [REG_W-1:0] dx_rd,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_wen,
  output logic             fd_wen,
  output logic             dx_wen,
  output logic             xm_wen,
  output logic             mw_wen,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  generate
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
      $error("pipe_hazard_ctrl: DRAIN_CYCLES must be at least 1");
    end
  endgenerate

  ctrl_state_e   r_state, w_next_state;
  logic [DW-1:0] r_drain_cnt;
  logic          w_drain_dec;
  logic          w_mem_stall;
  logic          w_load_use;

  assign w_mem_stall = imem_stall | dmem_stall;
  assign w_load_use  = dx_memread & dx_regwrite & (dx_rd != '0) &
                       ((id_use1 & (id_rs1 == dx_rd)) |
                        (id_use2 & (id_rs2 == dx_rd)));

  // Next-state and pipeline-register control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_wen       = 1'b0;
    fd_wen       = 1'b0;
    dx_wen       = 1'b0;
    xm_wen       = 1'b0;
    mw_wen       = 1'b0;
    fd_flush     = 1'b0;
    dx_bubble    = 1'b0;
    halted       = 1'b0;
    w_drain_dec  = 1'b0;
    w_next_state = r_state;
    if (rst) begin
      unique case (r_state)
        // MEM_WAIT is RUN with a frozen pipe; the first ready cycle is a
        // normal RUN cycle so no issue slot is lost.
        RUN, MEM_WAIT: begin
          if (w_mem_stall) begin
            w_next_state = MEM_WAIT;
          end else if (w_load_use) begin
            // Hold PC and F/D, inject a bubble; a taken branch re-evaluates next cycle.
            {dx_wen, xm_wen, mw_wen} = 3'b111;
            dx_bubble                = 1'b1;
            w_next_state             = RUN;
          end else if (id_halt) begin
            {fd_wen, dx_wen, xm_wen, mw_wen} = 4'b1111;
            fd_flush                         = 1'b1;
            w_next_state                     = DRAIN;
          end else begin
            {pc_wen, fd_wen, dx_wen, xm_wen, mw_wen} = 5'b11111;
            fd_flush                                 = id_branch_taken;
            w_next_state                             = RUN;
          end
        end
        // Let X, M and WB empty out while fetch stays parked.
        DRAIN: begin
          fd_flush = 1'b1;
          if (!w_mem_stall) begin
            {fd_wen, dx_wen, xm_wen, mw_wen} = 4'b1111;
            w_drain_dec                      = 1'b1;
            if (r_drain_cnt == DW'(1)) begin
              w_next_state = HALTED;
            end
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: w_next_state = RUN;
      endcase
    end
  end

  // State register and drain counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_drain_cnt <= DW'(DRAIN_CYCLES);
    end else begin
      r_state <= w_next_state;
      if (w_drain_dec) begin
        r_drain_cnt <= r_drain_cnt - 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = !pc_wen && (r_state != HALTED);
  assign w_flush_inc = fd_flush && ((r_state == RUN) || (r_state == MEM_WAIT));

  haz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  haz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
